// File: rtl/vram_pkg.sv
// Shared types for the VRAM responder: write-queue entry, FSM state, and
// the plane-to-byte-lane mapping.
package vram_pkg;

  typedef struct packed {
    logic [12:0] offset;
    logic [3:0]  be;
    logic [31:0] data;
  } vram_wr_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } vram_state_e;

  // Plane 0 lives in [31:24], plane 3 in [7:0].
  function automatic logic [3:0] plane_to_be(input logic [1:0] plane);
    return 4'b1000 >> plane;
  endfunction

endpackage

// File: rtl/vram_wq.sv
// CPU write queue: synchronous FIFO of vram_wr_t entries. With
// VRAM_WR_COALESCE_EN defined, a push to the tail's offset merges into it.
module vram_wq
  import vram_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  logic     push_i,
  input  vram_wr_t data_i,
  input  logic     pop_i,
`ifdef VRAM_WR_COALESCE_EN
  input  logic     head_lock_i,
`endif
  output vram_wr_t head_o,
  output logic     full_o,
  output logic     empty_o,
  output logic     drop_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  vram_wr_t        mem_q [DEPTH];
  logic [AW-1:0]   rd_ptr_q, wr_ptr_q, tail_ptr;
  logic [CW-1:0]   count_q;
  logic            merge, do_push, do_pop;

  assign tail_ptr = wr_ptr_q - AW'(1);
  assign full_o   = (count_q == CW'(DEPTH));
  assign empty_o  = (count_q == '0);
  assign head_o   = mem_q[rd_ptr_q];

`ifdef VRAM_WR_COALESCE_EN
  vram_wr_t merged;

  // The tail equals the head only when one entry is queued; that entry may
  // already be on the SDRAM bus, so it must not change under the request.
  assign merge = push_i && !empty_o && (mem_q[tail_ptr].offset == data_i.offset) &&
                 !(head_lock_i && count_q == CW'(1));

  always_comb begin
    merged    = mem_q[tail_ptr];
    merged.be = merged.be | data_i.be;
    for (int b = 0; b < 4; b++) begin
      if (data_i.be[b]) merged.data[b*8 +: 8] = data_i.data[b*8 +: 8];
    end
  end
`else
  assign merge = 1'b0;
`endif

  assign do_push = push_i && !merge && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign drop_o  = push_i && !merge && full_o;

  // NOTE: storage has no reset; the pointers and count alone define which
  // entries are live, so stale contents after reset are never observed.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
`ifdef VRAM_WR_COALESCE_EN
    else if (merge) mem_q[tail_ptr] <= merged;
`endif
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/vram_responder.sv
// VRAM responder: video word fetches and queued CPU byte writes share one
// SDRAM req/ack port. Optional write coalescing: VRAM_WR_COALESCE_EN.
module vram_responder
  import vram_pkg::*;
#(
  parameter logic [24:0] VRAM_BASE = 25'h0010000,
  parameter int          WQ_DEPTH  = 4
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [15:0] addr,
  input  logic [7:0]  din,
  input  logic        we,
  output logic        cpu_wait,
  input  logic        vid_rd,
  input  logic [12:0] vid_addr,
  output logic [31:0] vid_data,
  output logic        vid_valid,
  output logic        sd_req,
  output logic        sd_we,
  output logic [24:0] sd_addr,
  output logic [3:0]  sd_be,
  output logic [31:0] sd_wdata,
  input  logic        sd_ack,
  input  logic [31:0] sd_rdata,
  output logic        rd_overrun,
  output logic        wr_lost
);

  vram_state_e state_q, state_d;
  logic        we_q;
  logic        rd_pend_q, rd_pend_d;
  logic [12:0] rd_addr_q, rd_addr_d;
  logic        rd_overrun_q, wr_lost_q;
  logic [31:0] vid_data_q, vid_data_d;
  logic        vid_valid_q, vid_valid_d;
  logic        sd_req_q, sd_req_d;
  logic        sd_we_q, sd_we_d;
  logic [12:0] sd_off_q, sd_off_d;
  logic [3:0]  sd_be_q, sd_be_d;
  logic [31:0] sd_wdata_q, sd_wdata_d;

  logic        cpu_wr, rd_want, wq_pop, wq_full, wq_empty, wq_drop;
  logic [12:0] rd_off;
  vram_wr_t    new_entry, wq_head;

  assign cpu_wr    = we && !we_q && addr[15];
  assign new_entry = '{offset: addr[12:0], be: plane_to_be(addr[14:13]), data: {4{din}}};

  // A strobe this cycle is served without waiting for rd_pend to register.
  assign rd_want = rd_pend_q || vid_rd;
  assign rd_off  = vid_rd ? vid_addr : rd_addr_q;

`ifdef VRAM_WR_COALESCE_EN
  logic head_lock;
  assign head_lock = (state_q == WR) || (state_q == IDLE && !rd_want);
`endif

  vram_wq #(.DEPTH(WQ_DEPTH)) u_wq (
    .clk_i       (clk_sys),
    .rst_i       (reset),
    .push_i      (cpu_wr),
    .data_i      (new_entry),
    .pop_i       (wq_pop),
`ifdef VRAM_WR_COALESCE_EN
    .head_lock_i (head_lock),
`endif
    .head_o      (wq_head),
    .full_o      (wq_full),
    .empty_o     (wq_empty),
    .drop_o      (wq_drop)
  );

  // NOTE: every next-state signal takes its hold value first, so no path
  // through the case statement leaves one unassigned and no latch appears.
  always_comb begin
    state_d     = state_q;
    rd_pend_d   = rd_pend_q;
    rd_addr_d   = rd_addr_q;
    vid_data_d  = vid_data_q;
    vid_valid_d = 1'b0;
    sd_req_d    = sd_req_q;
    sd_we_d     = sd_we_q;
    sd_off_d    = sd_off_q;
    sd_be_d     = sd_be_q;
    sd_wdata_d  = sd_wdata_q;
    wq_pop      = 1'b0;

    if (vid_rd) begin
      rd_pend_d = 1'b1;
      rd_addr_d = vid_addr;
    end

    case (state_q)
      IDLE: begin
        if (rd_want) begin
          sd_req_d   = 1'b1;
          sd_we_d    = 1'b0;
          sd_off_d   = rd_off;
          sd_be_d    = 4'b1111;
          sd_wdata_d = '0;
          state_d    = RD;
        end else if (!wq_empty) begin
          sd_req_d   = 1'b1;
          sd_we_d    = 1'b1;
          sd_off_d   = wq_head.offset;
          sd_be_d    = wq_head.be;
          sd_wdata_d = wq_head.data;
          state_d    = WR;
        end
      end
      RD: begin
        if (sd_ack) begin
          sd_req_d    = 1'b0;
          vid_data_d  = sd_rdata;
          vid_valid_d = 1'b1;
          if (!vid_rd) rd_pend_d = 1'b0;
          state_d     = IDLE;
        end
      end
      WR: begin
        if (sd_ack) begin
          sd_req_d = 1'b0;
          wq_pop   = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // values from before the edge, independent of statement order.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      rd_pend_q    <= 1'b0;
      rd_addr_q    <= '0;
      rd_overrun_q <= 1'b0;
      wr_lost_q    <= 1'b0;
      vid_data_q   <= '0;
      vid_valid_q  <= 1'b0;
      sd_req_q     <= 1'b0;
      sd_we_q      <= 1'b0;
      sd_off_q     <= '0;
      sd_be_q      <= '0;
      sd_wdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      we_q         <= we;
      rd_pend_q    <= rd_pend_d;
      rd_addr_q    <= rd_addr_d;
      rd_overrun_q <= rd_overrun_q | (vid_rd & rd_pend_q);
      wr_lost_q    <= wr_lost_q | wq_drop;
      vid_data_q   <= vid_data_d;
      vid_valid_q  <= vid_valid_d;
      sd_req_q     <= sd_req_d;
      sd_we_q      <= sd_we_d;
      sd_off_q     <= sd_off_d;
      sd_be_q      <= sd_be_d;
      sd_wdata_q   <= sd_wdata_d;
    end
  end

  assign cpu_wait   = wq_full;
  assign vid_data   = vid_data_q;
  assign vid_valid  = vid_valid_q;
  assign sd_req     = sd_req_q;
  assign sd_we      = sd_we_q;
  assign sd_addr    = {VRAM_BASE[24:13], sd_off_q};
  assign sd_be      = sd_be_q;
  assign sd_wdata   = sd_wdata_q;
  assign rd_overrun = rd_overrun_q;
  assign wr_lost    = wr_lost_q;

endmodule

// File: tb/tb_vram_responder.sv
// Directed bench for vram_responder: cycle table plus hand-written sequences
// for queue-full, overrun, coalescing and reset-mid-transaction.
module tb_vram_responder;

  localparam logic [11:0] BASE_HI = 12'h008;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic [15:0] addr;
  logic [7:0]  din;
  logic        we;
  logic        cpu_wait;
  logic        vid_rd;
  logic [12:0] vid_addr;
  logic [31:0] vid_data;
  logic        vid_valid;
  logic        sd_req;
  logic        sd_we;
  logic [24:0] sd_addr;
  logic [3:0]  sd_be;
  logic [31:0] sd_wdata;
  logic        sd_ack;
  logic [31:0] sd_rdata;
  logic        rd_overrun;
  logic        wr_lost;

  int n_checks = 0;
  int n_pass   = 0;

  vram_responder dut (
    .clk_sys(clk_sys), .reset(reset), .addr(addr), .din(din), .we(we),
    .cpu_wait(cpu_wait), .vid_rd(vid_rd), .vid_addr(vid_addr),
    .vid_data(vid_data), .vid_valid(vid_valid), .sd_req(sd_req),
    .sd_we(sd_we), .sd_addr(sd_addr), .sd_be(sd_be), .sd_wdata(sd_wdata),
    .sd_ack(sd_ack), .sd_rdata(sd_rdata), .rd_overrun(rd_overrun),
    .wr_lost(wr_lost)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  din;
    logic        vid_rd;
    logic [12:0] vid_addr;
    logic        ack;
    logic [31:0] rdata;
    logic        e_req;
    logic        e_we;
    logic [12:0] e_off;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic        e_valid;
    logic [31:0] e_vdata;
  } vec_t;

  function automatic vec_t mk(
    input logic w, input logic [15:0] a, input logic [7:0] d,
    input logic r, input logic [12:0] va, input logic k, input logic [31:0] rd,
    input logic q, input logic qw, input logic [12:0] off, input logic [3:0] be,
    input logic [31:0] wd, input logic vv, input logic [31:0] vd);
    vec_t t;
    t.we = w; t.addr = a; t.din = d; t.vid_rd = r; t.vid_addr = va;
    t.ack = k; t.rdata = rd; t.e_req = q; t.e_we = qw; t.e_off = off;
    t.e_be = be; t.e_wdata = wd; t.e_valid = vv; t.e_vdata = vd;
    return t;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic idle_inputs();
    we = 1'b0; addr = '0; din = '0; vid_rd = 1'b0; vid_addr = '0;
    sd_ack = 1'b0; sd_rdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(negedge clk_sys);
    reset = 1'b0;
    @(negedge clk_sys);
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    we = 1'b1; addr = a; din = d;
    @(negedge clk_sys);
    we = 1'b0;
    @(negedge clk_sys);
  endtask

  task automatic vid_pulse(input logic [12:0] a);
    vid_rd = 1'b1; vid_addr = a;
    @(negedge clk_sys);
    vid_rd = 1'b0;
  endtask

  task automatic ack_cycle(input logic [31:0] r);
    sd_ack = 1'b1; sd_rdata = r;
    @(negedge clk_sys);
    sd_ack = 1'b0;
  endtask

  task automatic wait_req(input string name);
    for (int i = 0; i < 20 && !sd_req; i++) @(negedge clk_sys);
    check({name, " req"}, 64'(sd_req), 64'(1));
  endtask

  task automatic expect_write(input string name, input logic [12:0] off,
                              input logic [3:0] be, input logic [31:0] wd);
    wait_req(name);
    check({name, " we"},    64'(sd_we),    64'(1));
    check({name, " addr"},  64'(sd_addr),  64'({BASE_HI, off}));
    check({name, " be"},    64'(sd_be),    64'(be));
    check({name, " wdata"}, 64'(sd_wdata), 64'(wd));
  endtask

  task automatic expect_no_req(input string name);
    logic seen = 1'b0;
    repeat (5) begin
      @(negedge clk_sys);
      seen |= sd_req;
    end
    check(name, 64'(seen), 64'(0));
  endtask

  vec_t vecs[23];

  initial begin
    // Plane 1 of 0xA123 selects lane [23:16].
    vecs[0]  = mk(1, 16'hA123, 8'hA5, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0);
    vecs[1]  = mk(0, 0, 0, 0, 0, 0, 0,  1, 1, 13'h0123, 4'b0100, 32'hA5A5A5A5,  0, 0);
    vecs[2]  = mk(0, 0, 0, 0, 0, 0, 0,  1, 1, 13'h0123, 4'b0100, 32'hA5A5A5A5,  0, 0);
    vecs[3]  = mk(0, 0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0,  0, 0);
    vecs[4]  = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0);
    vecs[5]  = mk(0, 0, 0, 1, 13'h1F00, 0, 0,  1, 0, 13'h1F00, 4'b1111, 0,  0, 0);
    vecs[6]  = mk(0, 0, 0, 0, 0, 0, 0,  1, 0, 13'h1F00, 4'b1111, 0,  0, 0);
    vecs[7]  = mk(0, 0, 0, 0, 0, 0, 0,  1, 0, 13'h1F00, 4'b1111, 0,  0, 0);
    vecs[8]  = mk(0, 0, 0, 0, 0, 1, 32'h11223344,  0, 0, 0, 0, 0,  1, 32'h11223344);
    vecs[9]  = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 32'h11223344);
    vecs[10] = mk(1, 16'hC055, 8'h3C, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 32'h11223344);
    vecs[11] = mk(0, 0, 0, 0, 0, 0, 0,  1, 1, 13'h0055, 4'b0010, 32'h3C3C3C3C,  0, 32'h11223344);
    vecs[12] = mk(1, 16'h9ABC, 8'h01, 0, 0, 0, 0,  1, 1, 13'h0055, 4'b0010, 32'h3C3C3C3C,  0, 32'h11223344);
    vecs[13] = mk(0, 0, 0, 1, 13'h0042, 0, 0,  1, 1, 13'h0055, 4'b0010, 32'h3C3C3C3C,  0, 32'h11223344);
    vecs[14] = mk(1, 16'hFFFF, 8'h77, 0, 0, 0, 0,  1, 1, 13'h0055, 4'b0010, 32'h3C3C3C3C,  0, 32'h11223344);
    vecs[15] = mk(0, 0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0,  0, 32'h11223344);
    vecs[16] = mk(0, 0, 0, 0, 0, 0, 0,  1, 0, 13'h0042, 4'b1111, 0,  0, 32'h11223344);
    vecs[17] = mk(0, 0, 0, 0, 0, 1, 32'hCAFEF00D,  0, 0, 0, 0, 0,  1, 32'hCAFEF00D);
    vecs[18] = mk(0, 0, 0, 0, 0, 0, 0,  1, 1, 13'h1ABC, 4'b1000, 32'h01010101,  0, 32'hCAFEF00D);
    vecs[19] = mk(0, 0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0,  0, 32'hCAFEF00D);
    vecs[20] = mk(0, 0, 0, 0, 0, 0, 0,  1, 1, 13'h1FFF, 4'b0001, 32'h77777777,  0, 32'hCAFEF00D);
    vecs[21] = mk(0, 0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0,  0, 32'hCAFEF00D);
    vecs[22] = mk(0, 0, 0, 0, 0, 1, 32'hDEADBEEF,  0, 0, 0, 0, 0,  0, 32'hCAFEF00D);

    idle_inputs();
    reset = 1'b1;
    repeat (2) @(negedge clk_sys);
    check("reset sd_req",     64'(sd_req),     64'(0));
    check("reset vid_valid",  64'(vid_valid),  64'(0));
    check("reset vid_data",   64'(vid_data),   64'(0));
    check("reset cpu_wait",   64'(cpu_wait),   64'(0));
    check("reset flags",      64'({rd_overrun, wr_lost}), 64'(0));
    check("reset sd_payload", 64'({sd_we, sd_be, sd_wdata}), 64'(0));
    reset = 1'b0;
    @(negedge clk_sys);

    for (int i = 0; i < 23; i++) begin
      we = vecs[i].we; addr = vecs[i].addr; din = vecs[i].din;
      vid_rd = vecs[i].vid_rd; vid_addr = vecs[i].vid_addr;
      sd_ack = vecs[i].ack; sd_rdata = vecs[i].rdata;
      @(negedge clk_sys);
      check($sformatf("vec%0d sd_req", i),    64'(sd_req),    64'(vecs[i].e_req));
      check($sformatf("vec%0d vid_valid", i), 64'(vid_valid), 64'(vecs[i].e_valid));
      check($sformatf("vec%0d vid_data", i),  64'(vid_data),  64'(vecs[i].e_vdata));
      if (vecs[i].e_req) begin
        check($sformatf("vec%0d sd_we", i),   64'(sd_we),   64'(vecs[i].e_we));
        check($sformatf("vec%0d sd_addr", i), 64'(sd_addr), 64'({BASE_HI, vecs[i].e_off}));
        check($sformatf("vec%0d sd_be", i),   64'(sd_be),   64'(vecs[i].e_be));
        if (vecs[i].e_we)
          check($sformatf("vec%0d sd_wdata", i), 64'(sd_wdata), 64'(vecs[i].e_wdata));
      end
    end
    idle_inputs();
    check("table flags", 64'({cpu_wait, rd_overrun, wr_lost}), 64'(0));

    // Queue fills with the ack held low; the fifth write is dropped.
    do_reset();
    for (int k = 1; k <= 3; k++) cpu_write(16'h8000 + 16'(k), 8'h10 + 8'(k));
    check("3 queued cpu_wait", 64'(cpu_wait), 64'(0));
    cpu_write(16'h8004, 8'h14);
    check("4 queued cpu_wait", 64'(cpu_wait), 64'(1));
    check("4 queued wr_lost",  64'(wr_lost),  64'(0));
    cpu_write(16'h8005, 8'h15);
    check("5th wr_lost",       64'(wr_lost),  64'(1));
    check("5th cpu_wait",      64'(cpu_wait), 64'(1));
    check("frozen addr",       64'(sd_addr),  64'({BASE_HI, 13'h0001}));
    check("frozen wdata",      64'(sd_wdata), 64'(32'h11111111));

    // Two strobes two cycles apart while the write is stuck: latest wins.
    vid_pulse(13'h0AAA);
    check("first rd no overrun", 64'(rd_overrun), 64'(0));
    @(negedge clk_sys);
    vid_pulse(13'h0BBB);
    check("second rd overrun", 64'(rd_overrun), 64'(1));
    ack_cycle(32'h0);
    check("pop clears cpu_wait", 64'(cpu_wait), 64'(0));
    wait_req("overrun rd");
    check("overrun rd we",   64'(sd_we),   64'(0));
    check("overrun rd addr", 64'(sd_addr), 64'({BASE_HI, 13'h0BBB}));
    ack_cycle(32'h5555AAAA);
    check("overrun vid_valid", 64'(vid_valid), 64'(1));
    check("overrun vid_data",  64'(vid_data),  64'(32'h5555AAAA));
    @(negedge clk_sys);
    check("vid_valid one pulse", 64'(vid_valid), 64'(0));
    for (int k = 2; k <= 4; k++) begin
      expect_write($sformatf("drain%0d", k), 13'(k), 4'b1000, {4{8'h10 + 8'(k)}});
      ack_cycle(32'h0);
    end
    expect_no_req("dropped write absent");

    // Two writes to offset 0x0010 (planes 0 and 3) queued behind a read.
    do_reset();
    vid_pulse(13'h0005);
    cpu_write(16'h8010, 8'h12);
    cpu_write(16'hE010, 8'h34);
    ack_cycle(32'h0BADF00D);
`ifdef VRAM_WR_COALESCE_EN
    expect_write("merged", 13'h0010, 4'b1001, 32'h12121234);
`else
    expect_write("first of pair", 13'h0010, 4'b1000, 32'h12121212);
`endif
    cpu_write(16'hA200, 8'h99);
    check("busy before reset", 64'(sd_req), 64'(1));
    #2 reset = 1'b1;
    #1 check("reset drops sd_req", 64'(sd_req), 64'(0));
    check("reset clears vid_data", 64'(vid_data), 64'(0));
    @(negedge clk_sys);
    reset = 1'b0;
    ack_cycle(32'hFFFFFFFF);
    check("stale ack vid_valid", 64'(vid_valid), 64'(0));
    check("stale ack sd_req",    64'(sd_req),    64'(0));
    expect_no_req("queue lost on reset");
    check("post reset wr_lost",  64'(wr_lost),   64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
